// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
package rf_pkg;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_REG_WIDTH  = 32;
   localparam int DEF_REG_DEPTH  = 32;

   localparam logic [0:0] RF_INIT = 1'b0;
   localparam logic [0:0] RF_RUN  = 1'b1;

   localparam int WB0 = 0;
   localparam int WB1 = 1;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int REG_DEPTH  = DEF_REG_DEPTH,
   parameter int NUM_RD     = 2
)(
   input  logic                         clk,
   input  logic                         reg_rst,
   input  logic                         run,
   input  logic [1:0]                   wr_en,
   input  logic [2*ADDR_WIDTH-1:0]      wr_addr,
   input  logic                         issue_en,
   input  logic [ADDR_WIDTH-1:0]        issue_rd,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic                         issue_stall,
   output logic [NUM_RD-1:0]            rd_pending
);

   logic [REG_DEPTH-1:0] pending;
   logic [REG_DEPTH-1:0] clear_set;
   logic [REG_DEPTH-1:0] set_vec;
   logic                 accept;

   always_comb begin
      clear_set = '0;
      if (run) begin
         for (int k = WB0; k <= WB1; k++) begin
            if (wr_en[k]) clear_set[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
         end
      end
   end

   // A writeback in the same cycle resolves the hazard
   assign issue_stall = run & issue_en & (issue_rd != '0)
                      & pending[issue_rd] & ~clear_set[issue_rd];

   assign accept = run & issue_en & ~issue_stall & (issue_rd != '0);

   always_comb begin
      set_vec = '0;
      if (accept) set_vec[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reg_rst) pending <= '0;
      else         pending <= (pending & ~clear_set) | set_vec;
   end

   always_comb begin
      rd_pending = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_pending[i] = pending[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]
                       & ~clear_set[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with post-reset clear sweep and pending scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp_sb
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int REG_DEPTH  = DEF_REG_DEPTH,
   parameter int NUM_RD     = 2
)(
   input  logic                         clk,
   input  logic                         reg_rst,
   output logic                         rf_ready,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*REG_WIDTH-1:0]  rd_data,
   output logic [NUM_RD-1:0]            rd_pending,
   input  logic [1:0]                   wr_en,
   input  logic [2*ADDR_WIDTH-1:0]      wr_addr,
   input  logic [2*REG_WIDTH-1:0]       wr_data,
   input  logic                         issue_en,
   input  logic [ADDR_WIDTH-1:0]        issue_rd,
   output logic                         issue_stall
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_DEPTH - 1);

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [REG_WIDTH-1:0]  mem [REG_DEPTH];
   logic [ADDR_WIDTH-1:0] waddr [2];
   logic [REG_WIDTH-1:0]  wdata [2];

   assign rf_ready = (state == RF_RUN);

   always_comb begin
      for (int k = WB0; k <= WB1; k++) begin
         waddr[k] = wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         wdata[k] = wr_data[k*REG_WIDTH +: REG_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reg_rst) begin
         state <= RF_INIT;
         ptr   <= '0;
      end else if (state == RF_INIT) begin
         ptr <= ptr + 1'b1;
         if (ptr == LAST) state <= RF_RUN;
      end
   end

   // WB1 is applied last so it wins an address collision
   always_ff @(posedge clk) begin
      if (!reg_rst) begin
         if (state == RF_INIT) begin
            mem[ptr] <= '0;
         end else begin
            for (int k = WB0; k <= WB1; k++) begin
               if (wr_en[k] && waddr[k] != '0) mem[waddr[k]] <= wdata[k];
            end
         end
      end
   end

   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      logic [REG_WIDTH-1:0]  val;
      ra      = '0;
      val     = '0;
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra  = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         val = mem[ra];
`ifdef RF_BYPASS_EN
         for (int k = WB0; k <= WB1; k++) begin
            if (wr_en[k] && waddr[k] == ra) val = wdata[k];
         end
`endif
         if (rf_ready && ra != '0) rd_data[i*REG_WIDTH +: REG_WIDTH] = val;
      end
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .REG_DEPTH  (REG_DEPTH),
      .NUM_RD     (NUM_RD)
   ) u_sb (
      .clk         (clk),
      .reg_rst     (reg_rst),
      .run         (rf_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .issue_en    (issue_en),
      .issue_rd    (issue_rd),
      .rd_addr     (rd_addr),
      .issue_stall (issue_stall),
      .rd_pending  (rd_pending)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and model-checked bench for regfile_mp_sb with four read ports.
module tb_regfile_mp_sb;

   localparam int AW = 5;
   localparam int RW = 32;
   localparam int NR = 4;

   logic             clk = 1'b0;
   logic             reg_rst = 1'b1;
   logic             rf_ready;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*RW-1:0] rd_data;
   logic [NR-1:0]    rd_pending;
   logic [1:0]       wr_en;
   logic [2*AW-1:0]  wr_addr;
   logic [2*RW-1:0]  wr_data;
   logic             issue_en;
   logic [AW-1:0]    issue_rd;
   logic             issue_stall;

   int tests = 0;
   int fails = 0;

   regfile_mp_sb #(
      .ADDR_WIDTH (AW),
      .REG_WIDTH  (RW),
      .REG_DEPTH  (32),
      .NUM_RD     (NR)
   ) dut (
      .clk         (clk),
      .reg_rst     (reg_rst),
      .rf_ready    (rf_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_pending  (rd_pending),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_en    (issue_en),
      .issue_rd    (issue_rd),
      .issue_stall (issue_stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      issue_en = 1'b0;
      issue_rd = '0;
      rd_addr  = '0;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!rf_ready && n < 100) begin
         tick();
         n++;
      end
      tests++;
      if (n !== 32) begin
         fails++;
         $display("FAIL %s: ready after %0d cycles, expected 32", name, n);
      end
   endtask

   task automatic test_reset();
      idle();
      rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
      reg_rst = 1'b1;
      tick();
      tick();
      tests++;
      if ({rf_ready, rd_data, rd_pending, issue_stall} !== '0) begin
         fails++;
         $display("FAIL reset_outs: ready=%b data=%h pend=%b stall=%b, expected all 0",
                  rf_ready, rd_data, rd_pending, issue_stall);
      end
      reg_rst = 1'b0;
      wait_ready("sweep_len");
      for (int a = 0; a < 32; a += 4) begin
         rd_addr = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)};
         #1;
         tests++;
         if (rd_data !== '0) begin
            fails++;
            $display("FAIL clear_x%0d: data=%h, expected 0", a, rd_data);
         end
      end
      reg_rst = 1'b1;
      tick();
      reg_rst = 1'b0;
      repeat (10) tick();
      tests++;
      if (rf_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_sweep_ready: ready=%b, expected 0", rf_ready);
      end
      reg_rst = 1'b1;
      tick();
      reg_rst = 1'b0;
      wait_ready("restart_len");
   endtask

   task automatic test_bypass();
      logic [RW-1:0] exp_now;
`ifdef RF_BYPASS_EN
      exp_now = 32'hDEADBEEF;
`else
      exp_now = 32'h0;
`endif
      idle();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd5};
      wr_data = {32'h0, 32'hDEADBEEF};
      rd_addr = {5'd0, 5'd0, 5'd0, 5'd5};
      #1;
      tests++;
      if (rd_data[RW-1:0] !== exp_now) begin
         fails++;
         $display("FAIL wr_same_cycle: x5=%h, expected %h", rd_data[RW-1:0], exp_now);
      end
      tick();
      wr_en = 2'b00;
      #1;
      tests++;
      if (rd_data[RW-1:0] !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL wr_next_cycle: x5=%h, expected deadbeef", rd_data[RW-1:0]);
      end
   endtask

   task automatic test_dual_write();
      idle();
      wr_en   = 2'b11;
      wr_addr = {5'd7, 5'd7};
      wr_data = {32'h22, 32'h11};
      tick();
      idle();
      rd_addr = {5'd0, 5'd0, 5'd7, 5'd0};
      #1;
      tests++;
      if (rd_data[RW +: RW] !== 32'h22) begin
         fails++;
         $display("FAIL wb1_wins: x7=%h, expected 22", rd_data[RW +: RW]);
      end
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd0};
      wr_data = {32'h0, 32'hFFFF};
      rd_addr = {5'd0, 5'd0, 5'd0, 5'd0};
      #1;
      tests++;
      if (rd_data[RW-1:0] !== 32'h0) begin
         fails++;
         $display("FAIL x0_bypass: x0=%h, expected 0", rd_data[RW-1:0]);
      end
      tick();
      wr_en = 2'b00;
      #1;
      tests++;
      if (rd_data[RW-1:0] !== 32'h0) begin
         fails++;
         $display("FAIL x0_write: x0=%h, expected 0", rd_data[RW-1:0]);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      issue_en = 1'b1;
      issue_rd = 5'd9;
      #1;
      tests++;
      if (issue_stall !== 1'b0) begin
         fails++;
         $display("FAIL issue_first: stall=%b, expected 0", issue_stall);
      end
      tick();
      issue_en = 1'b0;
      rd_addr  = {5'd0, 5'd0, 5'd9, 5'd0};
      #1;
      tests++;
      if (rd_pending !== 4'b0010) begin
         fails++;
         $display("FAIL pend_set: pend=%b, expected 0010", rd_pending);
      end
      issue_en = 1'b1;
      #1;
      tests++;
      if (issue_stall !== 1'b1) begin
         fails++;
         $display("FAIL waw_stall: stall=%b, expected 1", issue_stall);
      end
      tick();
      issue_en = 1'b0;
      #1;
      tests++;
      if (rd_pending !== 4'b0010) begin
         fails++;
         $display("FAIL stall_hold: pend=%b, expected 0010", rd_pending);
      end
      issue_en = 1'b1;
      wr_en    = 2'b10;
      wr_addr  = {5'd9, 5'd0};
      wr_data  = {32'h99, 32'h0};
      #1;
      tests++;
      if ({issue_stall, rd_pending} !== 5'b0_0000) begin
         fails++;
         $display("FAIL wb_resolves: stall=%b pend=%b, expected 0 0000",
                  issue_stall, rd_pending);
      end
      tick();
      issue_en = 1'b0;
      wr_en    = 2'b00;
      #1;
      tests++;
      if (rd_pending !== 4'b0010 || rd_data[RW +: RW] !== 32'h99) begin
         fails++;
         $display("FAIL set_wins: pend=%b x9=%h, expected 0010 99",
                  rd_pending, rd_data[RW +: RW]);
      end
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd9};
      wr_data = {32'h0, 32'h1234};
      tick();
      wr_en = 2'b00;
      #1;
      tests++;
      if (rd_pending !== 4'b0000 || rd_data[RW +: RW] !== 32'h1234) begin
         fails++;
         $display("FAIL wb_clear: pend=%b x9=%h, expected 0000 1234",
                  rd_pending, rd_data[RW +: RW]);
      end
   endtask

   task automatic test_reg0_init();
      logic bad;
      idle();
      issue_en = 1'b1;
      issue_rd = 5'd0;
      #1;
      tests++;
      if (issue_stall !== 1'b0) begin
         fails++;
         $display("FAIL issue_x0: stall=%b, expected 0", issue_stall);
      end
      tick();
      issue_en = 1'b1;
      #1;
      tests++;
      if (issue_stall !== 1'b0 || rd_pending !== 4'b0000) begin
         fails++;
         $display("FAIL x0_no_pend: stall=%b pend=%b, expected 0 0000",
                  issue_stall, rd_pending);
      end
      idle();
      reg_rst = 1'b1;
      tick();
      reg_rst  = 1'b0;
      wr_en    = 2'b11;
      wr_addr  = {5'd3, 5'd3};
      wr_data  = {32'hAA, 32'hBB};
      issue_en = 1'b1;
      issue_rd = 5'd4;
      rd_addr  = {5'd7, 5'd9, 5'd4, 5'd3};
      bad = 1'b0;
      for (int c = 1; c <= 31; c++) begin
         tick();
         if ({rf_ready, rd_data, rd_pending, issue_stall} !== '0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL init_outs: nonzero output during sweep, expected all 0");
      end
      tick();
      wr_en    = 2'b00;
      issue_en = 1'b0;
      #1;
      tests++;
      if (rf_ready !== 1'b1 || rd_data[RW-1:0] !== 32'h0 || rd_pending !== 4'b0000) begin
         fails++;
         $display("FAIL init_ignored: ready=%b x3=%h pend=%b, expected 1 0 0000",
                  rf_ready, rd_data[RW-1:0], rd_pending);
      end
   endtask

   task automatic test_random();
      logic [RW-1:0] m_mem [32];
      logic [31:0]   m_pend;
      logic [31:0]   clr;
      logic [AW-1:0] wa [2];
      logic [RW-1:0] wd [2];
      logic [AW-1:0] a;
      logic [RW-1:0] v;
      logic [NR*RW-1:0] exp_data;
      logic [NR-1:0] exp_pend;
      logic          exp_stall;
      for (int r = 0; r < 32; r++) m_mem[r] = '0;
      m_pend = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         wr_en    = 2'($urandom_range(0, 3));
         wr_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
         wr_data  = {32'($urandom), 32'($urandom)};
         issue_en = 1'($urandom_range(0, 1));
         issue_rd = 5'($urandom_range(0, 11));
         rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                     5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
         #1;
         wa[0] = wr_addr[AW-1:0];
         wa[1] = wr_addr[2*AW-1:AW];
         wd[0] = wr_data[RW-1:0];
         wd[1] = wr_data[2*RW-1:RW];
         clr = '0;
         for (int k = 0; k < 2; k++) if (wr_en[k]) clr[wa[k]] = 1'b1;
         exp_stall = issue_en && issue_rd != 0 && m_pend[issue_rd] && !clr[issue_rd];
         for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            v = m_mem[a];
`ifdef RF_BYPASS_EN
            for (int k = 0; k < 2; k++) if (wr_en[k] && wa[k] == a) v = wd[k];
`endif
            if (a == 0) v = '0;
            exp_data[i*RW +: RW] = v;
            exp_pend[i] = (a != 0) && m_pend[a] && !clr[a];
         end
         tests++;
         if (rd_data !== exp_data) begin
            fails++;
            $display("FAIL rand_data c%0d: got %h, expected %h", cyc, rd_data, exp_data);
         end
         tests++;
         if (rd_pending !== exp_pend) begin
            fails++;
            $display("FAIL rand_pend c%0d: got %b, expected %b", cyc, rd_pending, exp_pend);
         end
         tests++;
         if (issue_stall !== exp_stall) begin
            fails++;
            $display("FAIL rand_stall c%0d: got %b, expected %b", cyc, issue_stall, exp_stall);
         end
         for (int k = 0; k < 2; k++) if (wr_en[k] && wa[k] != 0) m_mem[wa[k]] = wd[k];
         m_pend = m_pend & ~clr;
         if (issue_en && !exp_stall && issue_rd != 0) m_pend[issue_rd] = 1'b1;
         m_pend[0] = 1'b0;
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_bypass();
      test_dual_write();
      test_scoreboard();
      test_reg0_init();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
